dab_sequencer: RTL
==================

# dab_sequencer

Start-up, soft-start and protection sequencer for the dual-active-bridge converter. It sits between the external current command and `controlador2`, and between the `main` gate-pattern outputs and the pins. It precharges, then slew-limits the current reference once per switching period, and stops in an orderly way. On DC-link overvoltage it forces all eight gate signals low within two clocks.

## Interface
Parameters:
- `RAMP_STEP`, 12'd8: maximum `Iref_out` change per switching period (Iref LSBs).
- `IREF_MAX`, 12'sd1024: clamp magnitude applied to `Iref_cmd`.
- `VDC_UV`, 12'd64: minimum `Vdc1` for precharge to count.
- `VDC_OV`, 12'd3900: overvoltage trip level, applied to both `Vdc1` and `Vdc2`.
- `PRECHARGE_PERIODS`, 16'd1000: consecutive healthy periods required before switching starts.
- `FAULT_HOLD_PERIODS`, 16'd10000: minimum periods spent in FAULT.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `trigger` in 1: one-cycle pulse per DAB period, from `main`; this is the "tick".
- `enable` in 1: level; 1 requests converter run.
- `fault_clr` in 1: one-cycle pulse; acknowledges a fault.
- `Vdc1`, `Vdc2` in 12 (unsigned): measured DC-link voltages.
- `Iref_cmd` in 12 (signed): requested current reference.
- `Sp_in`, `Ss_in` in 4: gate patterns from `main`.
- `Iref_out` out 12 (signed): slew-limited reference to `controlador2`.
- `Sp_out`, `Ss_out` out 4: gated switch signals to the pins.
- `gate_en` out 1: registered switching enable.
- `state` out 3: encoded FSM state.
- `fault_code` out 2: bit0 = Vdc1 overvoltage, bit1 = Vdc2 overvoltage; sticky.

## Operation
Input handling:
- `Vdc1`/`Vdc2` are registered once, giving `v1_q`/`v2_q`.
- `ov1 = v1_q > VDC_OV`, `ov2 = v2_q > VDC_OV`, `ov = ov1 | ov2`.
- `Iref_cmd` is clamped to ±`IREF_MAX`, giving `tgt`.

Gating: `Sp_out = gate_en ? Sp_in : 0` and `Ss_out` likewise. These are the only combinational paths in the block.

Slew step, applied on a tick:
- Compute `d = tgt − Iref_out` in 13-bit signed.
- If |d| ≤ `RAMP_STEP`, set `Iref_out = tgt`.
- Otherwise move `Iref_out` toward `tgt` by exactly `RAMP_STEP`.
- No wrap-around is possible.

States and encodings:
- IDLE (0):
  - `gate_en`=0, `Iref_out`=0.
  - `enable`=1 & !`ov` → PRECHARGE, with the counter cleared.
- PRECHARGE (1):
  - `gate_en`=0.
  - On each tick: if `v1_q` ≥ `VDC_UV`, increment the counter; otherwise clear it.
  - Counter = `PRECHARGE_PERIODS` → RAMP, and `gate_en` goes to 1 on the same edge.
  - `enable`=0 → IDLE.
- RAMP (2):
  - Apply the slew step each tick.
  - `Iref_out` == `tgt` after the update → RUN.
  - `enable`=0 → STOP.
- RUN (3):
  - Apply the slew step each tick, so command changes are also rate-limited.
  - `enable`=0 → STOP.
- STOP (4):
  - Slew toward 0 each tick.
  - `Iref_out` reaches 0 → IDLE, with `gate_en`=0 on the same edge.
  - `enable`=1 → RAMP.
- FAULT (5):
  - `gate_en`=0, `Iref_out`=0.
  - The hold counter increments on each tick.
  - Exit to IDLE only when all of these hold: `fault_clr` pulse, !`ov`, hold counter ≥ `FAULT_HOLD_PERIODS`, and `enable`=0.
  - A `fault_clr` that does not meet all conditions is ignored.

Fault entry and priority:
- `ov` in any state other than FAULT → FAULT on the next edge.
- `fault_code` |= {`ov2`,`ov1`}, and the hold counter is cleared.
- `ov` has priority over every other transition in the same cycle.
- While in FAULT, further `ov` ORs into `fault_code`.
- `fault_code` clears only on exit from FAULT.

Boundary conditions:
- Ticks change `Iref_out` and the counters only. State transitions not marked "each tick" are evaluated every clock.
- Counters saturate and never wrap.

## Timing
- Reset values:
  - `state`=IDLE.
  - `gate_en`=0, so `Sp_out`=`Ss_out`=0.
  - `Iref_out`=0, `fault_code`=0, all counters 0, `v1_q`/`v2_q`=0.
- Reset mid-operation: gates go low immediately, asynchronously.
- Overvoltage latency:
  - Voltage above threshold sampled at edge k → `v_q` updates at k.
  - FAULT and `gate_en`=0 at edge k+1.
  - Pins are low 2 edges after the input change.
- `Iref_out` changes only on the edge following a `trigger` pulse; its latency is 1 clock.
- RAMP → RUN is entered on the same edge as the final step.

## Structure
- Shared package `dab_pkg`:
  - State enumeration constants and `fault_code` bit indices.
  - Widths: Iref 12, Vdc 12, counters 16.
- Single sub-module `slew_limiter`: combinational clamp-and-step. Inputs: `cur`, `tgt`, `step`. Output: `next`.
- The FSM, input registers, counters and gating are all in `dab_sequencer`.

## Test plan
1. Normal start-up:
   - Stimulus: reset, `Vdc1`=2000, `enable`=1, `Iref_cmd`=100, `PRECHARGE_PERIODS`=4, `RAMP_STEP`=8.
   - Required: `gate_en` rises on the 4th tick.
   - Required: `Iref_out` steps 8,16,…,96,100 and reaches RUN after 13 ticks.
2. Precharge restart:
   - Stimulus: `Vdc1` drops to 10 on tick 2 of PRECHARGE.
   - Required: counter clears; RAMP is entered only after 4 further healthy ticks.
3. Overvoltage during RUN:
   - Stimulus: `Vdc2`=3950.
   - Required: `Sp_out`/`Ss_out`=0 exactly 2 clocks later, `fault_code`=2'b10, `Iref_out`=0.
   - Required: `fault_clr` before hold expiry is ignored.
   - Required: after expiry, with `enable`=0 and `Vdc2`=2000, `fault_clr` → IDLE and `fault_code`=0.
4. Orderly stop and re-enable:
   - Stimulus: `enable`=0 at `Iref_out`=100 → STOP, `Iref_out` ramps 92,84,….
   - Stimulus: `enable`=1 at 60 → RAMP.
   - Required: it climbs back to 100 with `gate_en` never dropping.
5. Clamp and negative command:
   - Stimulus: `Iref_cmd`=−2048 with `IREF_MAX`=1024.
   - Required: `Iref_out` settles at −1024.
6. Mid-operation reset and collision priority:
   - Stimulus: assert `rst` in RUN.
   - Required: all outputs go to reset values asynchronously.
   - Stimulus: `ov` and `enable`=0 in the same cycle.
   - Required: FAULT, not STOP.

Source files
------------

// File: rtl/dab_pkg.sv
// rtl/dab_pkg.sv - shared types, widths and helpers for the DAB start-up sequencer
// Contents: state encoding, fault_code bit indices, datapath widths, Iref clamp helper.
package dab_pkg;

    localparam int IREF_W = 12;
    localparam int VDC_W  = 12;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_RAMP      = 3'd2,
        ST_RUN       = 3'd3,
        ST_STOP      = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    localparam int FC_OV1 = 0;
    localparam int FC_OV2 = 1;

    // Symmetric clamp to +/-lim; lim is assumed positive and <= 2047 so -lim fits.
    function automatic logic signed [IREF_W-1:0] clamp_iref(
        input logic signed [IREF_W-1:0] x,
        input logic signed [IREF_W-1:0] lim
    );
        logic signed [IREF_W-1:0] neg_lim;
        neg_lim = -lim;
        if (x > lim) begin
            clamp_iref = lim;
        end else if (x < neg_lim) begin
            clamp_iref = neg_lim;
        end else begin
            clamp_iref = x;
        end
    endfunction

endpackage

// File: rtl/slew_limiter.sv
// rtl/slew_limiter.sv - combinational rate limiter: moves cur toward tgt by at most step
// Ports: cur (signed, present value), tgt (signed, target), step (unsigned, max move),
//        next (signed, limited next value).
module slew_limiter
    import dab_pkg::*;
(
    input  logic signed [IREF_W-1:0] cur,
    input  logic signed [IREF_W-1:0] tgt,
    input  logic        [IREF_W-1:0] step,
    output logic signed [IREF_W-1:0] next
);

    logic signed [IREF_W:0] d;
    logic        [IREF_W:0] mag;

    // One extra bit keeps tgt - cur exact for any pair of 12-bit operands.
    assign d   = {tgt[IREF_W-1], tgt} - {cur[IREF_W-1], cur};
    assign mag = d[IREF_W] ? IREF_W'(0) - d : d;

    always_comb begin
        next = tgt;
        if (mag > {1'b0, step}) begin
            // |d| > step guarantees cur +/- step stays between cur and tgt, so no wrap.
            if (d[IREF_W]) begin
                next = cur - $signed(step);
            end else begin
                next = cur + $signed(step);
            end
        end
    end

endmodule

// File: rtl/dab_sequencer.sv
// rtl/dab_sequencer.sv - start-up, soft-start and overvoltage protection sequencer for the DAB
// Ports: clk, rst (async active-low); trigger (per-period tick), enable (run request),
//        fault_clr (fault acknowledge pulse); Vdc1/Vdc2 (DC-link voltages); Iref_cmd (signed
//        command); Sp_in/Ss_in (gate patterns); Iref_out (slew-limited reference); Sp_out/Ss_out
//        (gated pins); gate_en; state; fault_code (bit0 Vdc1 OV, bit1 Vdc2 OV, sticky).
module dab_sequencer
    import dab_pkg::*;
#(
    parameter logic        [IREF_W-1:0] RAMP_STEP          = 12'd8,
    parameter logic signed [IREF_W-1:0] IREF_MAX           = 12'sd1024,
    parameter logic        [VDC_W-1:0]  VDC_UV             = 12'd64,
    parameter logic        [VDC_W-1:0]  VDC_OV             = 12'd3900,
    parameter logic        [CNT_W-1:0]  PRECHARGE_PERIODS  = 16'd1000,
    parameter logic        [CNT_W-1:0]  FAULT_HOLD_PERIODS = 16'd10000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     trigger,
    input  logic                     enable,
    input  logic                     fault_clr,
    input  logic        [VDC_W-1:0]  Vdc1,
    input  logic        [VDC_W-1:0]  Vdc2,
    input  logic signed [IREF_W-1:0] Iref_cmd,
    input  logic        [3:0]        Sp_in,
    input  logic        [3:0]        Ss_in,
    output logic signed [IREF_W-1:0] Iref_out,
    output logic        [3:0]        Sp_out,
    output logic        [3:0]        Ss_out,
    output logic                     gate_en,
    output logic        [2:0]        state,
    output logic        [1:0]        fault_code
);

    state_t                   st;
    logic        [VDC_W-1:0]  v1_q;
    logic        [VDC_W-1:0]  v2_q;
    logic                     ov1;
    logic                     ov2;
    logic                     ov;
    logic signed [IREF_W-1:0] tgt;
    logic signed [IREF_W-1:0] slew_tgt;
    logic signed [IREF_W-1:0] slew_next;
    logic signed [IREF_W-1:0] iref_next;
    logic        [CNT_W-1:0]  pre_cnt;
    logic        [CNT_W-1:0]  pre_cnt_next;
    logic        [CNT_W-1:0]  hold_cnt;
    logic        [CNT_W-1:0]  hold_cnt_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q <= '0;
            v2_q <= '0;
        end else begin
            v1_q <= Vdc1;
            v2_q <= Vdc2;
        end
    end

    assign ov1 = v1_q > VDC_OV;
    assign ov2 = v2_q > VDC_OV;
    assign ov  = ov1 | ov2;

    assign tgt = clamp_iref(Iref_cmd, IREF_MAX);

    // STOP ramps down to zero; every other active state chases the clamped command.
    assign slew_tgt = (st == ST_STOP) ? '0 : tgt;

    slew_limiter u_slew (
        .cur  (Iref_out),
        .tgt  (slew_tgt),
        .step (RAMP_STEP),
        .next (slew_next)
    );

    // Reference only moves on the period tick; between ticks it holds.
    assign iref_next = trigger ? slew_next : Iref_out;

    always_comb begin
        pre_cnt_next = pre_cnt;
        if (trigger) begin
            if (v1_q >= VDC_UV) begin
                if (pre_cnt != '1) begin
                    pre_cnt_next = pre_cnt + 1'b1;
                end
            end else begin
                pre_cnt_next = '0;
            end
        end
    end

    always_comb begin
        hold_cnt_next = hold_cnt;
        if (trigger && (hold_cnt != '1)) begin
            hold_cnt_next = hold_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= ST_IDLE;
            gate_en    <= 1'b0;
            Iref_out   <= '0;
            fault_code <= '0;
            pre_cnt    <= '0;
            hold_cnt   <= '0;
        end else if (ov && (st != ST_FAULT)) begin
            // Overvoltage wins over every other transition in the same cycle.
            st         <= ST_FAULT;
            gate_en    <= 1'b0;
            Iref_out   <= '0;
            fault_code <= fault_code | {ov2, ov1};
            hold_cnt   <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    gate_en  <= 1'b0;
                    Iref_out <= '0;
                    if (enable) begin
                        st      <= ST_PRECHARGE;
                        pre_cnt <= '0;
                    end
                end
                ST_PRECHARGE: begin
                    gate_en <= 1'b0;
                    if (!enable) begin
                        st <= ST_IDLE;
                    end else begin
                        pre_cnt <= pre_cnt_next;
                        if (pre_cnt_next >= PRECHARGE_PERIODS) begin
                            st      <= ST_RAMP;
                            gate_en <= 1'b1;
                        end
                    end
                end
                ST_RAMP: begin
                    if (!enable) begin
                        st <= ST_STOP;
                    end else begin
                        Iref_out <= iref_next;
                        if (iref_next == tgt) begin
                            st <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        st <= ST_STOP;
                    end else begin
                        Iref_out <= iref_next;
                    end
                end
                ST_STOP: begin
                    if (enable) begin
                        // Resume from wherever the ramp-down got to; gates stay on.
                        st <= ST_RAMP;
                    end else begin
                        Iref_out <= iref_next;
                        if (iref_next == '0) begin
                            st      <= ST_IDLE;
                            gate_en <= 1'b0;
                        end
                    end
                end
                ST_FAULT: begin
                    gate_en    <= 1'b0;
                    Iref_out   <= '0;
                    hold_cnt   <= hold_cnt_next;
                    fault_code <= fault_code | {ov2, ov1};
                    if (fault_clr && !ov && !enable && (hold_cnt >= FAULT_HOLD_PERIODS)) begin
                        st         <= ST_IDLE;
                        fault_code <= '0;
                    end
                end
                default: begin
                    st       <= ST_IDLE;
                    gate_en  <= 1'b0;
                    Iref_out <= '0;
                end
            endcase
        end
    end

    assign state  = st;
    assign Sp_out = gate_en ? Sp_in : 4'h0;
    assign Ss_out = gate_en ? Ss_in : 4'h0;

endmodule
